// File: rtl/fixed_multiply.sv
// fixed_multiply: iterative unsigned fixed-point multiplier, product = (a * b) >> FRAC_A.
// Latency: result valid WIDTH_A+1 edges after the accept edge (WIDTH_A shift-add steps + 1 scale step).
// Backpressure: result held on product_out/overflow_out until ready_in; ready_out low from accept to handoff.
//
// Optional feature macro: FIXED_MULTIPLY_ROUND_EN
//   defined   -> r = (acc + 2^(FRAC_A-1)) >> FRAC_A  (round half up)
//   undefined -> r = acc >> FRAC_A                   (truncate toward zero)
//   Latency is identical in both builds.
//
// Ports:
//   clk_in           clock, all state on rising edge
//   rst_n_in         asynchronous active-low reset
//   valid_in         operands valid            ready_out     block can accept operands
//   multiplicand_in  Q(WIDTH_A-FRAC_A).FRAC_A  multiplier_in unsigned, any scale
//   valid_out        result valid              ready_in      downstream accepts result
//   product_out      result (saturated on overflow, same scale as multiplier)
//   overflow_out     true result >= 2^WIDTH_P

module fixed_multiply #(
  parameter int WIDTH_A = 26,
  parameter int FRAC_A  = 25,
  parameter int WIDTH_B = 24,
  parameter int WIDTH_P = 24
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [WIDTH_A-1:0] multiplicand_in,
  input  logic [WIDTH_B-1:0] multiplier_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [WIDTH_P-1:0] product_out,
  output logic               overflow_out
);

  // Full-precision accumulator never wraps: a*b < 2^(WIDTH_A+WIDTH_B).
  localparam int ACC_W = WIDTH_A + WIDTH_B;
  // One spare bit so a rounding carry out of the accumulator is not lost.
  localparam int SUM_W = ACC_W + 1;
  // Width of the scaled result before the overflow test.
  localparam int R_W   = SUM_W - FRAC_A;
  // Counter must reach WIDTH_A (the "all bits consumed" marker).
  localparam int CNT_W = $clog2(WIDTH_A + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_A);

`ifdef FIXED_MULTIPLY_ROUND_EN
  localparam logic [SUM_W-1:0] RND_CONST = SUM_W'(1) << (FRAC_A - 1);
`else
  localparam logic [SUM_W-1:0] RND_CONST = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH_A-1:0] mcand_q,  mcand_d;
  logic [WIDTH_B-1:0] mplier_q, mplier_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic               ready_q,  ready_d;
  logic               valid_q,  valid_d;
  logic [WIDTH_P-1:0] prod_q,   prod_d;
  logic               ovf_q,    ovf_d;

  // Datapath helpers
  logic [ACC_W-1:0]   addend;
  logic [SUM_W-1:0]   sum_w;
  logic [R_W-1:0]     r_w;
  logic               r_ovf;

  // Partial product for the current multiplicand bit.
  assign addend = ACC_W'(mplier_q) << cnt_q;

  // Scaling: optional half-LSB bias, then drop the fractional bits.
  assign sum_w  = {1'b0, acc_q} + RND_CONST;
  assign r_w    = R_W'(sum_w >> FRAC_A);

  // Anything at or above 2^WIDTH_P (including a rounding carry) is overflow.
  assign r_ovf  = |r_w[R_W-1:WIDTH_P];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        // ready_q comes up on the first edge after reset release.
        ready_d = 1'b1;
        if (valid_in && ready_q) begin
          mcand_d  = multiplicand_in;
          mplier_d = multiplier_in;
          acc_d    = '0;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          // All multiplicand bits consumed: scale, saturate and present.
          prod_d  = r_ovf ? '1 : r_w[WIDTH_P-1:0];
          ovf_d   = r_ovf;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          // No early exit on zero bits/operands: latency is data-independent.
          if (mcand_q[cnt_q]) begin
            acc_d = acc_q + addend;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Outputs stay frozen until the handoff; they keep their value after it.
        if (valid_q && ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready_out    = ready_q;
  assign valid_out    = valid_q;
  assign product_out  = prod_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_fixed_multiply.sv
// tb_fixed_multiply: directed + short random checks of fixed_multiply against an arithmetic model.
// Latency: n/a (bench).
// Backpressure: ready_in driven high, held low, and randomised across the phases.

module tb_fixed_multiply;

  localparam int WA = 26;
  localparam int FA = 25;
  localparam int WB = 24;
  localparam int WP = 24;

  typedef struct packed {
    logic          ovf;
    logic [WP-1:0] p;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          ready_out;
  logic [WA-1:0] mcand;
  logic [WB-1:0] mplier;
  logic          valid_out;
  logic          ready_in;
  logic [WP-1:0] product_out;
  logic          overflow_out;

  int   n_vec  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   n_done = 0;
  bit   stop_rnd = 1'b0;
  res_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_multiply #(
    .WIDTH_A(WA), .FRAC_A(FA), .WIDTH_B(WB), .WIDTH_P(WP)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .multiplicand_in (mcand),
    .multiplier_in   (mplier),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .product_out     (product_out),
    .overflow_out    (overflow_out)
  );

  // Reference: exact integer product, optional half-LSB bias, shift, saturate.
  function automatic res_t model(input logic [WA-1:0] a, input logic [WB-1:0] b);
    logic [63:0] full;
    logic [63:0] r;
    res_t        res;
    full = {38'd0, a} * {40'd0, b};
`ifdef FIXED_MULTIPLY_ROUND_EN
    full = full + (64'd1 << (FA - 1));
`endif
    r = full >> FA;
    if (r >= (64'd1 << WP)) begin
      res.ovf = 1'b1;
      res.p   = '1;
    end else begin
      res.ovf = 1'b0;
      res.p   = r[WP-1:0];
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Compare process: every cycle with valid_out, the DUT must show the oldest
  // outstanding expected result; accepts are seen on the same sampling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("rdy_vld_exclusive", {63'd0, valid_out && ready_out}, 64'd0);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          check("stream_product",  {40'd0, product_out},  {40'd0, exp_q[0].p});
          check("stream_overflow", {63'd0, overflow_out}, {63'd0, exp_q[0].ovf});
          if (ready_in) begin
            void'(exp_q.pop_front());
            n_done++;
          end
        end
      end
      if (valid_in && ready_out) exp_q.push_back(model(mcand, mplier));
    end
  end

  // Call just after a posedge; returns just after the accept edge with acc_cyc = that edge's index.
  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, output int acc_cyc);
    bit got;
    got      = 1'b0;
    acc_cyc  = 0;
    mcand    = a;
    mplier   = b;
    valid_in = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready_out) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("accept_wait");
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int v_cyc, output bit ok);
    ok    = 1'b0;
    v_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid_out) begin
        v_cyc = cyc;
        ok    = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b,
                        input logic [WP-1:0] ep, input logic eo, input string name);
    int ac, vc;
    bit ok;
    ready_in = 1'b1;
    send(a, b, ac);
    wait_valid(vc, ok);
    if (!ok) begin
      fail_now({name, "_valid"});
    end else begin
      check({name, "_latency"}, 64'(vc - ac), 64'(WA + 1));
      check({name, "_product"}, {40'd0, product_out}, {40'd0, ep});
      check({name, "_overflow"}, {63'd0, overflow_out}, {63'd0, eo});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ac, vc, base;
    bit  ok;
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    mcand    = '0;
    mplier   = '0;

    // Pin the model against hand-computed values.
    check("pin_model_mid",  64'(model(26'h14FAA14, 24'hC9FAA4)), {39'd0, 1'b0, 24'h846A96});
    check("pin_model_ovf",  64'(model(26'h3FFFFFF, 24'hC00000)), {39'd0, 1'b1, 24'hFFFFFF});
    check("pin_model_one",  64'(model(26'h2000000, 24'hABCDEF)), {39'd0, 1'b0, 24'hABCDEF});
`ifdef FIXED_MULTIPLY_ROUND_EN
    check("pin_model_small", 64'(model(26'h0000003, 24'h800000)), {39'd0, 1'b0, 24'h000001});
`else
    check("pin_model_small", 64'(model(26'h0000003, 24'h800000)), {39'd0, 1'b0, 24'h000000});
`endif

    // Reset state
    #3;
    check("rst_ready",    {63'd0, ready_out},    64'd0);
    check("rst_valid",    {63'd0, valid_out},    64'd0);
    check("rst_product",  {40'd0, product_out},  64'd0);
    check("rst_overflow", {63'd0, overflow_out}, 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, ready_out}, 64'd1);

    // Directed vectors
    run_op(26'h14FAA14, 24'hC9FAA4, 24'h846A96, 1'b0, "mid");
    run_op(26'h3FFFFFF, 24'hC00000, 24'hFFFFFF, 1'b1, "ovf");
`ifdef FIXED_MULTIPLY_ROUND_EN
    run_op(26'h0000003, 24'h800000, 24'h000001, 1'b0, "small");
    // 0xFFFFFF.C rounds up into 2^24: the rounding carry is overflow.
    run_op(26'h3FFFFFF, 24'h800000, 24'hFFFFFF, 1'b1, "rnd_carry");
`else
    run_op(26'h0000003, 24'h800000, 24'h000000, 1'b0, "small");
    run_op(26'h3FFFFFF, 24'h800000, 24'hFFFFFF, 1'b0, "rnd_carry");
`endif
    run_op(26'h2000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, "max_exact");
    run_op(26'h0000000, 24'hFFFFFF, 24'h000000, 1'b0, "zero_a");
    run_op(26'h3FFFFFF, 24'h000000, 24'h000000, 1'b0, "zero_b");

    // Hold under backpressure; valid_in pulses while busy must be ignored.
    ready_in = 1'b0;
    send(26'h2000000, 24'hABCDEF, ac);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("busy_ready_low", {63'd0, ready_out}, 64'd0);
      mcand    = 26'($urandom());
      mplier   = 24'($urandom());
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
    wait_valid(vc, ok);
    if (!ok) begin
      fail_now("hold_valid");
    end else begin
      check("hold_latency", 64'(vc - ac), 64'(WA + 1));
      for (int k = 0; k < 6; k++) begin
        check("hold_product", {40'd0, product_out}, {40'd0, 24'hABCDEF});
        check("hold_valid",   {63'd0, valid_out},   64'd1);
        check("hold_ready",   {63'd0, ready_out},   64'd0);
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_valid_drop", {63'd0, valid_out},   64'd0);
    check("handoff_ready_rise", {63'd0, ready_out},   64'd1);
    check("handoff_keep_prod",  {40'd0, product_out}, {40'd0, 24'hABCDEF});

    // Reset while busy: operation abandoned.
    send(26'h1234567, 24'h654321, ac);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid",   {63'd0, valid_out},   64'd0);
    check("midrst_ready",   {63'd0, ready_out},   64'd0);
    check("midrst_product", {40'd0, product_out}, 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("postrst_ready",   {63'd0, ready_out},   64'd1);
    check("postrst_valid",   {63'd0, valid_out},   64'd0);
    check("postrst_product", {40'd0, product_out}, 64'd0);
    repeat (35) @(posedge clk);
    #1;
    check("postrst_no_result", {63'd0, valid_out}, 64'd0);

    // Back-to-back random ops with random downstream readiness.
    base     = n_done;
    stop_rnd = 1'b0;
    fork
      begin
        while (!stop_rnd) begin
          @(posedge clk);
          #1;
          if (!stop_rnd) ready_in = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      ra = 26'($urandom());
      rb = 24'($urandom());
      if (i % 5 == 0) ra = '0;
      if (i % 7 == 3) rb = '0;
      if (i % 4 == 1) ra = 26'h3FFFFFF;
      send(ra, rb, ac);
    end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (n_done >= base + 16) begin
        ok = 1'b1;
        break;
      end
    end
    stop_rnd = 1'b1;
    @(posedge clk);
    #2;
    ready_in = 1'b1;
    if (!ok) fail_now("random_drain");
    repeat (40) @(posedge clk);
    #1;
    check("random_count",   64'(n_done - base), 64'd16);
    check("queue_empty",    64'(exp_q.size()),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
